// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute stage:
//   - opcode encodings OP_PASSA .. OP_PASSB
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - default datapath and shift-amount widths
//   - helper that identifies the iterative shift/rotate opcodes
// Optional feature macro used by the top level: ALU_SKID_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 20;
   localparam int ALU_SHW   = 4;
   localparam int ALU_MSB   = ALU_WIDTH - 1;

   localparam logic [3:0] OP_PASSA = 4'd0;
   localparam logic [3:0] OP_NOT   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SHL   = 4'd5;
   localparam logic [3:0] OP_SHR   = 4'd6;
   localparam logic [3:0] OP_ROTL  = 4'd7;
   localparam logic [3:0] OP_ROTR  = 4'd8;
   localparam logic [3:0] OP_INC   = 4'd9;
   localparam logic [3:0] OP_DEC   = 4'd10;
   localparam logic [3:0] OP_ADD   = 4'd11;
   localparam logic [3:0] OP_ADDC  = 4'd12;
   localparam logic [3:0] OP_SUB   = 4'd13;
   localparam logic [3:0] OP_EQ    = 4'd14;
   localparam logic [3:0] OP_PASSB = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) || (op == OP_ROTR);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational ALU operator set. Logic and arithmetic ops produce
// their full result; shift/rotate opcodes produce a single one-bit step, which
// the execute FSM iterates.
// Ports:
//   op_i        opcode
//   a_i, b_i    operands
//   carry_i     persistent carry flag (consumed by ADDC)
//   result_o    result (one-bit step for shift/rotate)
//   carry_out_o new carry/borrow value
//   carry_we_o  1 when the opcode updates the carry flag
// -----------------------------------------------------------------------------
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_out_o,
   output logic             carry_we_o
);

   // One extra bit: its top bit is the carry-out for additions and the
   // borrow for subtractions (a wrapped negative difference sets it).
   logic [WIDTH:0] sum;

   always_comb begin
      sum         = '0;
      result_o    = a_i;
      carry_out_o = 1'b0;
      carry_we_o  = 1'b0;
      case (op_i)
         OP_PASSA: result_o = a_i;
         OP_NOT:   result_o = ~a_i;
         OP_AND:   result_o = a_i & b_i;
         OP_OR:    result_o = a_i | b_i;
         OP_XOR:   result_o = a_i ^ b_i;
         OP_SHL:   result_o = {a_i[WIDTH-2:0], 1'b0};
         OP_SHR:   result_o = {1'b0, a_i[WIDTH-1:1]};
         OP_ROTL:  result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
         OP_ROTR:  result_o = {a_i[0], a_i[WIDTH-1:1]};
         OP_INC: begin
            sum         = {1'b0, a_i} + (WIDTH+1)'(1);
            result_o    = sum[WIDTH-1:0];
            carry_out_o = sum[WIDTH];
            carry_we_o  = 1'b1;
         end
         OP_DEC: begin
            sum         = {1'b0, a_i} - (WIDTH+1)'(1);
            result_o    = sum[WIDTH-1:0];
            carry_out_o = sum[WIDTH];
            carry_we_o  = 1'b1;
         end
         OP_ADD: begin
            sum         = {1'b0, a_i} + {1'b0, b_i};
            result_o    = sum[WIDTH-1:0];
            carry_out_o = sum[WIDTH];
            carry_we_o  = 1'b1;
         end
         OP_ADDC: begin
            sum         = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(carry_i);
            result_o    = sum[WIDTH-1:0];
            carry_out_o = sum[WIDTH];
            carry_we_o  = 1'b1;
         end
         OP_SUB: begin
            sum         = {1'b0, a_i} - {1'b0, b_i};
            result_o    = sum[WIDTH-1:0];
            carry_out_o = sum[WIDTH];
            carry_we_o  = 1'b1;
         end
         OP_EQ: begin
            // Compare only: the result is forced to zero, the borrow is kept.
            sum         = {1'b0, a_i} - {1'b0, b_i};
            result_o    = '0;
            carry_out_o = sum[WIDTH];
            carry_we_o  = 1'b1;
         end
         OP_PASSB: result_o = b_i;
         default:  result_o = a_i;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Sequential execute stage around alu_comb_core. Accepts one operation over a
// valid/ready handshake, runs shifts/rotates one bit per cycle, keeps a
// persistent carry flag, and holds the registered result and flags until
// writeback takes them.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        upstream handshake
//   in_op, in_a, in_b,
//   in_shamt                 operation, sampled only on accept
//   out_valid/out_ready      downstream handshake
//   out_result               registered result
//   out_zero, out_sign       result flags (EQ: a==b, a<b unsigned)
//   out_carry                persistent carry/borrow flag
// Optional feature: define ALU_SKID_EN to accept a new op in DONE in the same
// cycle the current result is consumed (1 op/cycle for single-cycle ops).
// -----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SHW   = ALU_SHW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [SHW-1:0]   in_shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_sign,
   output logic             out_carry
);

   state_e           state_q,  state_d;
   logic [SHW-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0] work_q,   work_d;
   logic [3:0]       op_q,     op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q,   zero_d;
   logic             sign_q,   sign_d;
   logic             carry_q,  carry_d;

   logic             accept;
   logic             launch;
   logic [3:0]       core_op;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_res;
   logic             core_carry;
   logic             core_we;
   logic [WIDTH-1:0] launch_res;

   // While shifting the core steps the work register; otherwise it evaluates
   // the incoming operation directly.
   assign core_op = (state_q == ST_SHIFT) ? op_q   : in_op;
   assign core_a  = (state_q == ST_SHIFT) ? work_q : in_a;

   alu_comb_core #(.WIDTH(WIDTH)) u_core (
      .op_i        (core_op),
      .a_i         (core_a),
      .b_i         (in_b),
      .carry_i     (carry_q),
      .result_o    (core_res),
      .carry_out_o (core_carry),
      .carry_we_o  (core_we)
   );

   // A shift by zero completes immediately with the operand unchanged; the
   // core would otherwise return a one-bit step.
   assign launch_res = is_shift_op(in_op) ? in_a : core_res;

`ifdef ALU_SKID_EN
   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
`else
   assign in_ready = (state_q == ST_IDLE);
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
      sign_d   = sign_q;
      carry_d  = carry_q;
      launch   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) launch = 1'b1;
         end
         ST_SHIFT: begin
            work_d = core_res;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d  = ST_DONE;
               result_d = core_res;
               zero_d   = (core_res == '0);
               sign_d   = core_res[WIDTH-1];
            end
         end
         ST_DONE: begin
            // accept can only be high here when the skid path is built in.
            if (out_ready) begin
               state_d = ST_IDLE;
               if (accept) launch = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
         op_d = in_op;
         if (is_shift_op(in_op) && (in_shamt != '0)) begin
            work_d  = in_a;
            cnt_d   = in_shamt;
            state_d = ST_SHIFT;
         end else begin
            state_d  = ST_DONE;
            result_d = launch_res;
            if (in_op == OP_EQ) begin
               zero_d = (in_a == in_b);
               sign_d = core_carry;   // borrow of a-b == (a < b) unsigned
            end else begin
               zero_d = (launch_res == '0);
               sign_d = launch_res[WIDTH-1];
            end
            if (core_we) carry_d = core_carry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         work_q   <= '0;
         op_q     <= OP_PASSA;
         result_q <= '0;
         zero_q   <= 1'b0;
         sign_q   <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         sign_q   <= sign_d;
         carry_q  <= carry_d;
      end
   end

   assign out_valid  = (state_q == ST_DONE);
   assign out_result = result_q;
   assign out_zero   = zero_q;
   assign out_sign   = sign_q;
   assign out_carry  = carry_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed bench for alu_exec_unit. Expected results come from an independent
// reference model and are queued when an op is driven, then popped and
// compared when out_valid rises. Skid-path throughput is exercised when
// ALU_SKID_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int W = 20;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_op;
   logic [W-1:0] in_a, in_b;
   logic [3:0]   in_shamt;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_zero, out_sign, out_carry;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(W), .SHW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_shamt   (in_shamt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_sign   (out_sign),
      .out_carry  (out_carry)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         s;
      logic         c;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;
   logic m_carry;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model written from the operator definitions, using wide
   // integer arithmetic and whole-amount shifts.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input int sh, input logic cin);
      exp_t         e;
      longint       s;
      logic [2*W-1:0] dbl;
      e.res = '0;
      e.c   = cin;
      s     = 0;
      case (op)
         4'd0:  e.res = a;
         4'd1:  e.res = ~a;
         4'd2:  e.res = a & b;
         4'd3:  e.res = a | b;
         4'd4:  e.res = a ^ b;
         4'd5:  e.res = a << sh;
         4'd6:  e.res = a >> sh;
         4'd7:  begin dbl = {a, a} << sh; e.res = dbl[2*W-1:W]; end
         4'd8:  begin dbl = {a, a} >> sh; e.res = dbl[W-1:0]; end
         4'd9:  begin e.res = a + W'(1); e.c = (a == {W{1'b1}}); end
         4'd10: begin e.res = a - W'(1); e.c = (a == '0); end
         4'd11: begin s = longint'(a) + longint'(b); e.res = W'(s); e.c = (s >= (64'sd1 << W)); end
         4'd12: begin s = longint'(a) + longint'(b) + longint'(cin); e.res = W'(s); e.c = (s >= (64'sd1 << W)); end
         4'd13: begin e.res = a - b; e.c = (a < b); end
         4'd14: begin e.res = '0; e.c = (a < b); end
         default: e.res = b;
      endcase
      if (op == 4'd14) begin
         e.z = (a == b);
         e.s = (a < b);
      end else begin
         e.z = (e.res == '0);
         e.s = e.res[W-1];
      end
      return e;
   endfunction

   // Drive one op, wait for acceptance, then wait for the result and compare
   // against the scoreboard head. lat counts cycles from the accept edge
   // (1 = result visible right after the accept edge).
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] sh, input string tag,
                        output int lat, output bit rdy_seen);
      exp_t e;
      int   n;
      e = model(op, a, b, int'(sh), m_carry);
      m_carry = e.c;
      sb.push_back(e);
      in_op = op; in_a = a; in_b = b; in_shamt = sh; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check({tag, " accept"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      // Scramble inputs after accept: the DUT must have sampled them already.
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_shamt = 4'($urandom);
      @(negedge clk);
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, " result"}, 32'(out_result), 32'(e.res));
         check({tag, " zero"},   32'(out_zero),   32'(e.z));
         check({tag, " sign"},   32'(out_sign),   32'(e.s));
         check({tag, " carry"},  32'(out_carry),  32'(e.c));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      bit           rs;
      logic [W-1:0] xa[4];
      logic [W-1:0] xb[4];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_a = '0; in_b = '0; in_shamt = '0;
      m_carry = 1'b0;
      repeat (2) @(negedge clk);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready",  32'(in_ready),  32'd1);
      check("rst result",    32'(out_result), 32'd0);
      check("rst zero",      32'(out_zero),   32'd0);
      check("rst sign",      32'(out_sign),   32'd0);
      check("rst carry",     32'(out_carry),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Carry chain: ADD overflow then ADDC consumes the carry.
      do_op(OP_ADD, 20'hFFFFF, 20'h00001, 4'd0, "add", lat, rs);
      check("add lat", 32'(lat), 32'd1);
      check("add const result", 32'(out_result), 32'h0);
      check("add const carry",  32'(out_carry),  32'd1);
      do_op(OP_ADDC, 20'h00001, 20'h00002, 4'd0, "addc", lat, rs);
      check("addc const result", 32'(out_result), 32'h4);

      // Iterative shift latency and in_ready low while shifting.
      do_op(OP_SHL, 20'h00001, 20'h0, 4'd5, "shl5", lat, rs);
      check("shl5 lat", 32'(lat), 32'd6);
      check("shl5 in_ready low", 32'(rs), 32'd0);
      check("shl5 const result", 32'(out_result), 32'h20);
      do_op(OP_ROTR, 20'h00001, 20'h0, 4'd1, "rotr1", lat, rs);
      check("rotr1 const result", 32'(out_result), 32'h80000);
      check("rotr1 lat", 32'(lat), 32'd2);

      // Borrow then a logic op that must leave carry alone.
      do_op(OP_SUB, 20'h00003, 20'h00005, 4'd0, "sub", lat, rs);
      check("sub const result", 32'(out_result), 32'hFFFFE);
      do_op(OP_AND, 20'hF0F0F, 20'h0FF00, 4'd0, "and", lat, rs);
      check("and const result", 32'(out_result), 32'h00F00);
      check("and const carry",  32'(out_carry),  32'd1);

      // Backpressure: result held, nothing accepted.
      @(negedge clk);
      out_ready = 1'b0;
      do_op(OP_OR, 20'h12340, 20'h00005, 4'd0, "bp", lat, rs);
      in_valid = 1'b1; in_op = OP_ADD; in_a = 20'h1; in_b = 20'h1; in_shamt = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp hold valid",    32'(out_valid),  32'd1);
         check("bp hold result",   32'(out_result), 32'h12345);
         check("bp hold zero",     32'(out_zero),   32'd0);
         check("bp hold sign",     32'(out_sign),   32'd0);
         check("bp hold carry",    32'(out_carry),  32'(m_carry));
         check("bp hold in_ready", 32'(in_ready),   32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp drained valid",    32'(out_valid), 32'd0);
      check("bp drained in_ready", 32'(in_ready),  32'd1);

      // Reset in the middle of a shift (cnt==3).
      in_op = OP_SHL; in_a = 20'h1; in_b = '0; in_shamt = 4'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mid-shift busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst out_valid", 32'(out_valid),  32'd0);
      check("midrst in_ready",  32'(in_ready),   32'd1);
      check("midrst result",    32'(out_result), 32'd0);
      check("midrst carry",     32'(out_carry),  32'd0);
      rst_n = 1'b1;
      m_carry = 1'b0;
      @(negedge clk);
      do_op(OP_ADD, 20'h00002, 20'h00003, 4'd0, "post-rst add", lat, rs);
      check("post-rst add const", 32'(out_result), 32'h5);

      // Sweep every opcode with random operands; includes EQ, DEC at 0, shamt 15.
      for (int i = 0; i < 16; i++) begin
         logic [W-1:0] ra, rb;
         logic [3:0]   rsh;
         ra  = W'($urandom);
         rb  = (i == 14) ? ra : W'($urandom);
         rsh = (i == 7) ? 4'd15 : 4'($urandom);
         if (i == 10) ra = '0;
         do_op(4'(i), ra, rb, rsh, $sformatf("sweep op%0d", i), lat, rs);
         check($sformatf("sweep op%0d lat", i), 32'(lat),
               32'((is_shift_op(4'(i)) && rsh != 0) ? int'(rsh) + 1 : 1));
      end
      do_op(OP_EQ, 20'h00010, 20'h00020, 4'd0, "eq lt", lat, rs);
      do_op(OP_EQ, 20'h00030, 20'h00020, 4'd0, "eq gt", lat, rs);

`ifdef ALU_SKID_EN
      // Four back-to-back XORs: one result per cycle, out_valid held high.
      for (int k = 0; k < 4; k++) begin
         xa[k] = W'($urandom);
         xb[k] = W'($urandom);
      end
      @(negedge clk);
      in_op = OP_XOR; in_shamt = '0; in_a = xa[0]; in_b = xb[0]; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (k < 3) begin
            in_a = xa[k+1]; in_b = xb[k+1];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check($sformatf("skid%0d valid", k),  32'(out_valid),  32'd1);
         check($sformatf("skid%0d result", k), 32'(out_result), 32'(xa[k] ^ xb[k]));
      end
      @(negedge clk);
      check("skid tail valid", 32'(out_valid), 32'd0);
`else
      xa[0] = '0;
      xb[0] = xa[0];
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
